// File: rtl/ex_except_stage.sv
// EX-stage exception merge: flags ADD/ADDI/SUB overflow, drives the EX/MEM register and holds one pending exception.
// Optional taken-exception counter enabled by defining EX_EXC_COUNT_EN.
module ex_except_stage #(
   parameter int EXC_W  = 9,
   parameter int OF_BIT = 5,
   parameter int CODE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [EXC_W-1:0]  in_except,
   input  logic [31:0]       instruct,
   input  logic [31:0]       pc,
   input  logic              of,
   input  logic              stall,
   input  logic              flush,
   input  logic              exc_ack,
   output logic              out_valid,
   output logic [EXC_W-1:0]  out_except,
   output logic [31:0]       out_instruct,
   output logic [31:0]       out_pc,
   output logic              exc_req,
   output logic [CODE_W-1:0] exc_code,
   output logic [31:0]       epc,
   output logic [15:0]       exc_count
);

   typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} state_t;

   state_t             state_r;
   logic [5:0]         opcode_s;
   logic [5:0]         funct_s;
   logic               trap_arith_s;
   logic               ovf_s;
   logic [EXC_W-1:0]   merged_s;
   logic               take_s;

   // Highest set bit wins: larger index means higher priority.
   function automatic logic [CODE_W-1:0] top_index(input logic [EXC_W-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = {CODE_W{1'b0}};
      for (int i = 0; i < EXC_W; i++) begin
         if (v[i]) idx = CODE_W'(i);
         else      idx = idx;
      end
      return idx;
   endfunction

   // Overflow detection for the trapping adds and the merged exception vector.
   always_comb begin
      opcode_s     = instruct[31:26];
      funct_s      = instruct[5:0];
      trap_arith_s = 1'b0;
      case (opcode_s)
         6'b000000: trap_arith_s = (funct_s == 6'b100000) || (funct_s == 6'b100010);
         6'b001000: trap_arith_s = 1'b1;
         default:   trap_arith_s = 1'b0;
      endcase
      ovf_s            = in_valid & of & trap_arith_s;
      merged_s         = in_except;
      merged_s[OF_BIT] = ovf_s;
      take_s           = (state_r == IDLE) && !stall && !flush && in_valid &&
                         (merged_s != {EXC_W{1'b0}});
   end

   // Exception FSM and EX/MEM register; flush beats stall, ack is honoured even while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         exc_req      <= 1'b0;
         exc_code     <= {CODE_W{1'b0}};
         epc          <= 32'h0000_0000;
         out_valid    <= 1'b0;
         out_except   <= {EXC_W{1'b0}};
         out_instruct <= 32'h0000_0000;
         out_pc       <= 32'h0000_0000;
      end else begin
         if ((state_r == PENDING) && exc_ack) begin
            state_r <= IDLE;
            exc_req <= 1'b0;
         end else if (take_s) begin
            state_r  <= PENDING;
            exc_req  <= 1'b1;
            exc_code <= top_index(merged_s);
            epc      <= pc;
         end

         if (flush) begin
            out_valid  <= 1'b0;
            out_except <= {EXC_W{1'b0}};
         end else if (!stall) begin
            if (state_r == PENDING) begin
               out_valid <= 1'b0;
            end else begin
               out_valid    <= in_valid;
               out_except   <= merged_s;
               out_instruct <= instruct;
               out_pc       <= pc;
            end
         end
      end
   end

`ifdef EX_EXC_COUNT_EN
   logic [15:0] exc_count_r;

   // Saturating count of IDLE->PENDING transitions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_count_r <= 16'h0000;
      end else if (take_s && (exc_count_r != 16'hFFFF)) begin
         exc_count_r <= exc_count_r + 16'h0001;
      end
   end

   assign exc_count = exc_count_r;
`else
   assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_except_stage.sv
// Randomized and directed bench for ex_except_stage against a cycle-level behavioural model.
module tb_ex_except_stage;

   localparam int EXC_W  = 9;
   localparam int OF_BIT = 5;
   localparam int CODE_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [EXC_W-1:0]  in_except;
   logic [31:0]       instruct;
   logic [31:0]       pc;
   logic              of;
   logic              stall;
   logic              flush;
   logic              exc_ack;
   logic              out_valid;
   logic [EXC_W-1:0]  out_except;
   logic [31:0]       out_instruct;
   logic [31:0]       out_pc;
   logic              exc_req;
   logic [CODE_W-1:0] exc_code;
   logic [31:0]       epc;
   logic [15:0]       exc_count;

   int n_total = 0;
   int n_bad   = 0;

   // Model state
   bit               m_pend;
   logic             m_ov;
   logic [EXC_W-1:0] m_oe;
   logic [31:0]      m_oi, m_op, m_epc;
   int               m_code;
   int               m_cnt;

   ex_except_stage #(.EXC_W(EXC_W), .OF_BIT(OF_BIT), .CODE_W(CODE_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_except(in_except),
      .instruct(instruct), .pc(pc), .of(of), .stall(stall), .flush(flush),
      .exc_ack(exc_ack), .out_valid(out_valid), .out_except(out_except),
      .out_instruct(out_instruct), .out_pc(out_pc), .exc_req(exc_req),
      .exc_code(exc_code), .epc(epc), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         0: r = {6'b000000, r[25:6], 6'b100000};   // ADD
         1: r = {6'b000000, r[25:6], 6'b100001};   // ADDU
         2: r = {6'b000000, r[25:6], 6'b100010};   // SUB
         3: r = {6'b000000, r[25:6], 6'b100011};   // SUBU
         4: r = {6'b001000, r[25:0]};              // ADDI
         5: r = {6'b001001, r[25:0]};              // ADDIU
         default: r = r;
      endcase
      return r;
   endfunction

   function automatic bit traps(input logic [31:0] w);
      bit rtype;
      rtype = (w[31:26] == 6'd0);
      return (rtype && (w[5:0] == 6'd32)) || (rtype && (w[5:0] == 6'd34)) || (w[31:26] == 6'd8);
   endfunction

   function automatic int highest(input logic [EXC_W-1:0] v);
      for (int i = EXC_W - 1; i >= 0; i--) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_ov = 1'b0; m_oe = '0; m_oi = 32'd0; m_op = 32'd0;
      m_epc = 32'd0; m_code = 0; m_cnt = 0;
   endtask

   // Next-state of the model from the inputs currently applied.
   task automatic model_edge();
      logic [EXC_W-1:0] merged;
      bit was_pend;
      merged = in_except;
      merged[OF_BIT] = in_valid && of && traps(instruct);
      was_pend = m_pend;
      if (was_pend && exc_ack) m_pend = 0;
      else if (!was_pend && !stall && !flush && in_valid && merged != 0) begin
         m_pend = 1; m_code = highest(merged); m_epc = pc;
`ifdef EX_EXC_COUNT_EN
         if (m_cnt < 65535) m_cnt++;
`endif
      end
      if (flush) begin
         m_ov = 1'b0; m_oe = '0;
      end else if (!stall) begin
         if (was_pend) m_ov = 1'b0;
         else begin
            m_ov = in_valid; m_oe = merged; m_oi = instruct; m_op = pc;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".out_valid"},    32'(out_valid),    32'(m_ov));
      check({tag, ".out_except"},   32'(out_except),   32'(m_oe));
      check({tag, ".out_instruct"}, out_instruct,      m_oi);
      check({tag, ".out_pc"},       out_pc,            m_op);
      check({tag, ".exc_req"},      32'(exc_req),      32'(m_pend));
      check({tag, ".exc_code"},     32'(exc_code),     32'(m_code));
      check({tag, ".epc"},          epc,               m_epc);
      check({tag, ".exc_count"},    32'(exc_count),    32'(m_cnt));
   endtask

   task automatic drive(input logic v, input logic [EXC_W-1:0] e, input logic [31:0] w,
                        input logic [31:0] p, input logic o, input logic s,
                        input logic f, input logic a);
      in_valid = v; in_except = e; instruct = w; pc = p; of = o;
      stall = s; flush = f; exc_ack = a;
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk); @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // ADD overflow
      drive(1'b1, '0, mk(0), 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("add_ovf");
      check("add_ovf.except_k", 32'(out_except), 32'h020);
      check("add_ovf.code_k",   32'(exc_code),   32'd5);
      check("add_ovf.epc_k",    epc,             32'h0040_0010);
      check("add_ovf.req_k",    32'(exc_req),    32'd1);
      drive(1'b0, '0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("ack0");

      // ADDU never overflows
      drive(1'b1, '0, mk(1), 32'h0040_0014, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("addu");
      check("addu.except_k", 32'(out_except), 32'h000);
      check("addu.req_k",    32'(exc_req),    32'd0);

      // Priority code, ack squashes the instruction in the ack cycle
      drive(1'b1, 9'h104, mk(2), 32'h0040_0020, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("prio");
      check("prio.code_k", 32'(exc_code), 32'd8);
      drive(1'b1, '0, mk(6), 32'h0040_0024, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("ack1");
      check("ack1.req_k",   32'(exc_req),   32'd0);
      check("ack1.valid_k", 32'(out_valid), 32'd0);

      // Stalled ADDI overflow is taken only after the stall
      drive(1'b1, '0, mk(4), 32'h0040_0030, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("stall");
         check("stall.req_k", 32'(exc_req), 32'd0);
      end
      stall = 1'b0;
      cycle("unstall");
      check("unstall.req_k",  32'(exc_req),  32'd1);
      check("unstall.code_k", 32'(exc_code), 32'd5);
      drive(1'b1, '0, mk(6), 32'h0040_0034, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle("flush_stall");
      check("flush_stall.valid_k", 32'(out_valid), 32'd0);
      check("flush_stall.req_k",   32'(exc_req),   32'd1);

      // Asynchronous reset while pending
      drive(1'b1, '0, mk(6), 32'h0040_0038, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.req",   32'(exc_req),   32'd0);
      check("async_rst.epc",   epc,            32'd0);
      check("async_rst.valid", 32'(out_valid), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Three acked exceptions for the counter
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 9'h001, mk(6), 32'h1000 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
         cycle("cnt_take");
         drive(1'b0, '0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         cycle("cnt_ack");
      end
`ifdef EX_EXC_COUNT_EN
      check("cnt3", 32'(exc_count), 32'd3);
      force dut.exc_count_r = 16'hFFFE;
      #1 release dut.exc_count_r;
      m_cnt = 65534;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 9'h002, mk(6), 32'h2000 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
         cycle("sat_take");
         drive(1'b0, '0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         cycle("sat_ack");
      end
      check("cnt_sat", 32'(exc_count), 32'h0000_FFFF);
`else
      check("cnt_off", 32'(exc_count), 32'd0);
`endif

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         logic [EXC_W-1:0] e;
         e = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom) : '0;
         drive(($urandom_range(0, 3) != 0), e, mk($urandom_range(0, 7)), $urandom,
               1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0));
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
